// File: rtl/mmu_ctrl_if.sv
// mmu_ctrl_if: register-bus, status and translation-settings bundle for mmu_ctrl.
//   slave  modport : the controller side (mmu_ctrl).
//   master modport : the host / MMU-datapath side.
// Ports:
//   wr_en_i, reg_sel_i, wr_data_i, rd_data_o : register access (rd_data_o is combinational)
//   busy_i                                   : memory transaction outstanding
//   exception_i, fault_addr_i                : translation fault report
//   en_o, mask_o, offset_o, size_o           : active translation settings
//   pending_o, fault_valid_o, fault_addr_o   : status
interface mmu_ctrl_if;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;

  logic          wr_en_i;
  logic [SW-1:0] reg_sel_i;
  logic [DW-1:0] wr_data_i;
  logic [DW-1:0] rd_data_o;
  logic          busy_i;
  logic          exception_i;
  logic [DW-1:0] fault_addr_i;
  logic          en_o;
  logic [DW-1:0] mask_o;
  logic [DW-1:0] offset_o;
  logic [DW-1:0] size_o;
  logic          pending_o;
  logic          fault_valid_o;
  logic [DW-1:0] fault_addr_o;

  modport slave (
    input  wr_en_i, reg_sel_i, wr_data_i, busy_i, exception_i, fault_addr_i,
    output rd_data_o, en_o, mask_o, offset_o, size_o, pending_o,
           fault_valid_o, fault_addr_o
  );

  modport master (
    output wr_en_i, reg_sel_i, wr_data_i, busy_i, exception_i, fault_addr_i,
    input  rd_data_o, en_o, mask_o, offset_o, size_o, pending_o,
           fault_valid_o, fault_addr_o
  );
endinterface

// File: rtl/mmu_ctrl.sv
// mmu_ctrl: shadow/active MMU translation settings with a deferred, atomic commit.
// Software writes MASK/OFFSET/SIZE/EN into a shadow set; a CTRL COMMIT moves the FSM
// to WAIT, and the first cycle with busy_i low copies shadow to active in one edge.
// Ports:
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : mmu_ctrl_if.slave (register bus, busy/fault inputs, settings/status outputs)
// Optional feature: define MMU_FAULT_CAPTURE_EN to build the sticky first-fault capture
// registers; without it the fault status reads as zero and no fault state exists.
module mmu_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  mmu_ctrl_if.slave  bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] SEL_MASK   = SW'(0);
  localparam logic [SW-1:0] SEL_OFFSET = SW'(1);
  localparam logic [SW-1:0] SEL_SIZE   = SW'(2);
  localparam logic [SW-1:0] SEL_CTRL   = SW'(3);
  localparam logic [SW-1:0] SEL_FAULT  = SW'(4);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_wr_ctrl;
  logic          w_shadow_wr;
  logic          w_load_active;

  logic          r_sh_en;
  logic [DW-1:0] r_sh_mask;
  logic [DW-1:0] r_sh_offset;
  logic [DW-1:0] r_sh_size;
  logic          r_act_en;
  logic [DW-1:0] r_act_mask;
  logic [DW-1:0] r_act_offset;
  logic [DW-1:0] r_act_size;

  logic          w_fault_valid;
  logic [DW-1:0] w_fault_addr;
  logic [DW-1:0] w_rd_data;

  assign w_wr_ctrl = bus.wr_en_i && (bus.reg_sel_i == SEL_CTRL);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: shadow is writable only in IDLE; WAIT drains to a single-edge load
  always_comb begin
    w_state_nxt   = r_state;
    w_shadow_wr   = 1'b0;
    w_load_active = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_shadow_wr = 1'b1;
        if (w_wr_ctrl && bus.wr_data_i[1]) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.busy_i) begin
          w_load_active = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
    endcase
  end

  // Shadow and active register sets; active loads all four fields on one edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sh_en      <= 1'b0;
      r_sh_mask    <= '0;
      r_sh_offset  <= '0;
      r_sh_size    <= '0;
      r_act_en     <= 1'b0;
      r_act_mask   <= '0;
      r_act_offset <= '0;
      r_act_size   <= '0;
    end else begin
      if (w_shadow_wr && bus.wr_en_i) begin
        case (bus.reg_sel_i)
          SEL_MASK:   r_sh_mask   <= bus.wr_data_i;
          SEL_OFFSET: r_sh_offset <= bus.wr_data_i;
          SEL_SIZE:   r_sh_size   <= bus.wr_data_i;
          SEL_CTRL:   r_sh_en     <= bus.wr_data_i[0];
          default:    ;
        endcase
      end
      if (w_load_active) begin
        r_act_en     <= r_sh_en;
        r_act_mask   <= r_sh_mask;
        r_act_offset <= r_sh_offset;
        r_act_size   <= r_sh_size;
      end
    end
  end

`ifdef MMU_FAULT_CAPTURE_EN
  logic          r_fault_valid;
  logic [DW-1:0] r_fault_addr;
  logic          w_fault_clr;

  assign w_fault_clr = w_wr_ctrl && bus.wr_data_i[2];

  // First fault wins; a new fault arriving with FAULT_CLR is captured
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
    end else if (bus.exception_i && (!r_fault_valid || w_fault_clr)) begin
      r_fault_valid <= 1'b1;
      r_fault_addr  <= bus.fault_addr_i;
    end else if (w_fault_clr) begin
      r_fault_valid <= 1'b0;
    end
  end

  assign w_fault_valid = r_fault_valid;
  assign w_fault_addr  = r_fault_addr;
`else
  logic w_unused_fault;
  assign w_unused_fault = ^{bus.exception_i, bus.fault_addr_i};
  assign w_fault_valid  = 1'b0;
  assign w_fault_addr   = '0;
`endif

  // Register read mux; CTRL write-1 bits always read back as 0
  always_comb begin
    w_rd_data = '0;
    case (bus.reg_sel_i)
      SEL_MASK:   w_rd_data = r_sh_mask;
      SEL_OFFSET: w_rd_data = r_sh_offset;
      SEL_SIZE:   w_rd_data = r_sh_size;
      SEL_CTRL: begin
        w_rd_data[0] = r_sh_en;
        w_rd_data[8] = (r_state == ST_WAIT);
        w_rd_data[9] = w_fault_valid;
      end
      SEL_FAULT:  w_rd_data = w_fault_addr;
      default:    w_rd_data = '0;
    endcase
  end

  assign bus.rd_data_o     = w_rd_data;
  assign bus.en_o          = r_act_en;
  assign bus.mask_o        = r_act_mask;
  assign bus.offset_o      = r_act_offset;
  assign bus.size_o        = r_act_size;
  assign bus.pending_o     = (r_state == ST_WAIT);
  assign bus.fault_valid_o = w_fault_valid;
  assign bus.fault_addr_o  = w_fault_addr;

endmodule

// File: tb/tb_mmu_ctrl.sv
// tb_mmu_ctrl: directed scenarios followed by random traffic, each cycle compared
// against a behavioural model of the shadow/active register sets and fault capture.
module tb_mmu_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mmu_ctrl_if u_if();

  mmu_ctrl u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Model: index 0 MASK, 1 OFFSET, 2 SIZE (index 3 unused)
  logic [31:0] m_sh  [4];
  logic [31:0] m_act [4];
  logic        m_sh_en, m_act_en, m_pend, m_fv;
  logic [31:0] m_fa;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_rd(input logic [2:0] sel);
    logic [31:0] v;
    case (sel)
      3'd0, 3'd1, 3'd2: v = m_sh[sel[1:0]];
      3'd3:             v = {22'd0, m_fv, m_pend, 7'd0, m_sh_en};
      3'd4:             v = m_fa;
      default:          v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = 32'd0;
      m_act[i] = 32'd0;
    end
    m_sh_en = 1'b0; m_act_en = 1'b0; m_pend = 1'b0; m_fv = 1'b0; m_fa = 32'd0;
  endtask

  // One clock edge of the specified behaviour, from pre-edge inputs and state
  task automatic m_step(input logic rst, input logic wr, input logic [2:0] sel,
                        input logic [31:0] data, input logic busy,
                        input logic exc, input logic [31:0] fa);
    logic wctrl;
    wctrl = wr && (sel == 3'd3);
    if (!rst) begin
      m_clear();
      return;
    end
`ifdef MMU_FAULT_CAPTURE_EN
    if (exc && (!m_fv || (wctrl && data[2]))) begin
      m_fv = 1'b1;
      m_fa = fa;
    end else if (wctrl && data[2]) begin
      m_fv = 1'b0;
    end
`endif
    if (m_pend) begin
      if (!busy) begin
        m_act_en = m_sh_en;
        for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
        m_pend = 1'b0;
      end
    end else begin
      if (wr && sel < 3'd3) m_sh[sel[1:0]] = data;
      if (wctrl) begin
        m_sh_en = data[0];
        m_pend  = data[1];
      end
    end
  endtask

  task automatic check_outs(input logic [2:0] sel);
    chk("en",         {31'd0, u_if.en_o},          {31'd0, m_act_en});
    chk("mask",       u_if.mask_o,                 m_act[0]);
    chk("offset",     u_if.offset_o,               m_act[1]);
    chk("size",       u_if.size_o,                 m_act[2]);
    chk("pending",    {31'd0, u_if.pending_o},     {31'd0, m_pend});
    chk("fault_vld",  {31'd0, u_if.fault_valid_o}, {31'd0, m_fv});
    chk("fault_addr", u_if.fault_addr_o,           m_fa);
    chk("rd_post",    u_if.rd_data_o,              m_rd(sel));
  endtask

  // Drive after the falling edge, check the read mux, clock, then check all outputs
  task automatic cycle(input logic rst, input logic wr, input logic [2:0] sel,
                       input logic [31:0] data, input logic busy,
                       input logic exc, input logic [31:0] fa);
    @(negedge clk);
    reset_n           = rst;
    u_if.wr_en_i      = wr;
    u_if.reg_sel_i    = sel;
    u_if.wr_data_i    = data;
    u_if.busy_i       = busy;
    u_if.exception_i  = exc;
    u_if.fault_addr_i = fa;
    #1;
    if (rst) chk("rd_pre", u_if.rd_data_o, m_rd(sel));
    @(posedge clk);
    m_step(rst, wr, sel, data, busy, exc, fa);
    #1;
    check_outs(sel);
  endtask

  task automatic wr_reg(input logic [2:0] sel, input logic [31:0] data, input logic busy);
    cycle(1'b1, 1'b1, sel, data, busy, 1'b0, 32'd0);
  endtask

  task automatic idle(input logic [2:0] sel, input logic busy);
    cycle(1'b1, 1'b0, sel, 32'd0, busy, 1'b0, 32'd0);
  endtask

  initial begin
    reset_n           = 1'b0;
    u_if.wr_en_i      = 1'b0;
    u_if.reg_sel_i    = 3'd0;
    u_if.wr_data_i    = 32'd0;
    u_if.busy_i       = 1'b0;
    u_if.exception_i  = 1'b0;
    u_if.fault_addr_i = 32'd0;
    m_clear();

    // Reset state
    cycle(1'b0, 1'b0, 3'd3, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 3'd3, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("rst_en",   {31'd0, u_if.en_o}, 32'd0);
    chk("rst_ctrl", u_if.rd_data_o,     32'd0);

    // Basic commit: outputs hold through the CTRL edge, all change on the next one
    wr_reg(3'd0, 32'hFFFF0000, 1'b0);
    wr_reg(3'd1, 32'h00100000, 1'b0);
    wr_reg(3'd2, 32'h0000FFFF, 1'b0);
    chk("r028_shadow_hold", u_if.mask_o, 32'd0);
    wr_reg(3'd3, 32'h00000003, 1'b0);
    chk("r028_hold_en",   {31'd0, u_if.en_o},      32'd0);
    chk("r028_pend",      {31'd0, u_if.pending_o}, 32'd1);
    chk("r028_ctrl_rd",   u_if.rd_data_o,          32'h00000101);
    idle(3'd3, 1'b0);
    chk("r028_en",     {31'd0, u_if.en_o}, 32'd1);
    chk("r028_mask",   u_if.mask_o,        32'hFFFF0000);
    chk("r028_offset", u_if.offset_o,      32'h00100000);
    chk("r028_size",   u_if.size_o,        32'h0000FFFF);

    // Busy stall: commit waits while busy_i is high
    wr_reg(3'd0, 32'hF0F0F0F0, 1'b1);
    wr_reg(3'd3, 32'h00000002, 1'b1);
    for (int i = 0; i < 10; i++) idle(3'd0, 1'b1);
    chk("r029_pend", {31'd0, u_if.pending_o}, 32'd1);
    chk("r029_hold", u_if.mask_o,             32'hFFFF0000);
    idle(3'd0, 1'b0);
    chk("r029_mask",    u_if.mask_o,             32'hF0F0F0F0);
    chk("r029_en_off",  {31'd0, u_if.en_o},      32'd0);
    chk("r029_pend_lo", {31'd0, u_if.pending_o}, 32'd0);

    // Shadow writes ignored in WAIT
    wr_reg(3'd3, 32'h00000003, 1'b1);
    wr_reg(3'd0, 32'h12345678, 1'b1);
    chk("r030_shadow", u_if.rd_data_o, 32'hF0F0F0F0);
    idle(3'd0, 1'b0);
    chk("r030_mask", u_if.mask_o,      32'hF0F0F0F0);
    chk("r030_en",   {31'd0, u_if.en_o}, 32'd1);

    // Reset mid-WAIT discards the commit
    wr_reg(3'd1, 32'hAAAA5555, 1'b1);
    wr_reg(3'd3, 32'h00000003, 1'b1);
    cycle(1'b0, 1'b0, 3'd1, 32'd0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) idle(3'd1, 1'b0);
    chk("r031_en",     {31'd0, u_if.en_o},      32'd0);
    chk("r031_offset", u_if.offset_o,           32'd0);
    chk("r031_pend",   {31'd0, u_if.pending_o}, 32'd0);
    chk("r031_shadow", u_if.rd_data_o,          32'd0);

    // Fault capture
    cycle(1'b1, 1'b0, 3'd4, 32'd0, 1'b0, 1'b1, 32'hDEAD0000);
    cycle(1'b1, 1'b0, 3'd4, 32'd0, 1'b0, 1'b1, 32'hBEEF0000);
`ifdef MMU_FAULT_CAPTURE_EN
    chk("r032_first", u_if.fault_addr_o, 32'hDEAD0000);
`else
    chk("r033_addr",  u_if.fault_addr_o, 32'd0);
`endif
    cycle(1'b1, 1'b1, 3'd3, 32'h00000004, 1'b0, 1'b1, 32'h0000CAFE);
`ifdef MMU_FAULT_CAPTURE_EN
    chk("r032_setwin_v", {31'd0, u_if.fault_valid_o}, 32'd1);
    chk("r032_setwin_a", u_if.fault_addr_o,           32'h0000CAFE);
    chk("r032_ctrl_rd",  u_if.rd_data_o,              32'h00000200);
`else
    chk("r033_valid",    {31'd0, u_if.fault_valid_o}, 32'd0);
    chk("r033_ctrl_rd",  u_if.rd_data_o,              32'd0);
`endif
    idle(3'd4, 1'b0);
`ifdef MMU_FAULT_CAPTURE_EN
    chk("r032_sel4", u_if.rd_data_o, 32'h0000CAFE);
`else
    chk("r033_sel4", u_if.rd_data_o, 32'd0);
`endif
    wr_reg(3'd3, 32'h00000004, 1'b0);
    chk("fault_clr", {31'd0, u_if.fault_valid_o}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_wr, r_busy, r_exc;
      logic [2:0]  r_sel;
      logic [31:0] r_data, r_fa;
      r_rst  = ($urandom_range(0, 49) != 0);
      r_wr   = 1'($urandom_range(0, 1));
      r_sel  = 3'($urandom_range(0, 7));
      r_data = $urandom;
      r_busy = ($urandom_range(0, 2) == 0);
      r_exc  = ($urandom_range(0, 3) == 0);
      r_fa   = $urandom;
      cycle(r_rst, r_wr, r_sel, r_data, r_busy, r_exc, r_fa);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
